// File: rtl/mem_arb_pkg.sv
// Shared types for the unified-memory port arbiter.
// State encoding and the access-width code used for instruction fetches.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2,
        DRAIN  = 2'd3
    } arb_state_t;

    // Fetches are always full-word accesses.
    localparam logic [2:0] MW_WORD = 3'b010;

endpackage

// File: rtl/arb_watchdog.sv
// Purpose: sticky error when an outstanding memory request waits too long for mem_ack.
// Latency: err rises in the TIMEOUT-th consecutive wait cycle (registered, set one edge earlier).
// Backpressure: none; observation only, never blocks the access in flight.
module arb_watchdog #(
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst_n,
    input  logic mem_req,
    input  logic mem_ack,
    output logic err
);

    localparam int CW = $clog2(TIMEOUT);

    logic [CW-1:0] wait_cnt;

    // wait_cnt holds the number of wait cycles already completed, so the flag is
    // registered at the end of wait cycle TIMEOUT-1 and is visible during cycle TIMEOUT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
            err      <= 1'b0;
        end else begin
            if (mem_ack) begin
                wait_cnt <= '0;
            end else if (mem_req) begin
                if (wait_cnt != CW'(TIMEOUT - 1))
                    wait_cnt <= wait_cnt + CW'(1);
                if (wait_cnt >= CW'(TIMEOUT - 2))
                    err <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Purpose: shares one single-ported memory between the fetch port and the load/store port.
// Latency: grant cycle, then mem_req held until mem_ack; x_valid/x_rdata the cycle after the ack.
// Backpressure: stall_if/stall_mem held high until the ack cycle of the requester's own access.
module mem_port_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 64
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    input  logic          i_kill,
    output logic          i_valid,
    output logic [DW-1:0] i_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [2:0]    d_width,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_valid,
    output logic [DW-1:0] d_rdata,
    output logic          stall_if,
    output logic          stall_mem,
    output logic          mem_req,
    output logic          mem_we,
    output logic [2:0]    mem_width,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic          mem_ack,
    input  logic [DW-1:0] mem_rdata,
    output logic          err
);

    import mem_arb_pkg::*;

    arb_state_t state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_width <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            i_valid   <= 1'b0;
            d_valid   <= 1'b0;
            i_rdata   <= '0;
            d_rdata   <= '0;
        end else begin
            i_valid <= 1'b0;
            d_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    // Data wins: it belongs to the older instruction in the pipe.
                    if (d_req) begin
                        state     <= BUSY_D;
                        mem_req   <= 1'b1;
                        mem_we    <= d_we;
                        mem_width <= d_width;
                        mem_addr  <= d_addr;
                        mem_wdata <= d_wdata;
                    end else if (i_req && !i_kill) begin
                        state     <= BUSY_I;
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b0;
                        mem_width <= MW_WORD;
                        mem_addr  <= i_addr;
                        mem_wdata <= '0;
                    end
                end
                BUSY_I: begin
                    if (mem_ack) begin
                        state   <= IDLE;
                        mem_req <= 1'b0;
                        if (!i_kill) begin
                            i_valid <= 1'b1;
                            i_rdata <= mem_rdata;
                        end
                    end else if (i_kill) begin
                        // The memory cannot abort, so wait out the ack and drop it.
                        state <= DRAIN;
                    end
                end
                BUSY_D: begin
                    if (mem_ack) begin
                        state   <= IDLE;
                        mem_req <= 1'b0;
                        d_valid <= 1'b1;
                        d_rdata <= mem_rdata;
                    end
                end
                DRAIN: begin
                    if (mem_ack) begin
                        state   <= IDLE;
                        mem_req <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign stall_if  = i_req & ~((state == BUSY_I) & mem_ack & ~i_kill);
    assign stall_mem = d_req & ~((state == BUSY_D) & mem_ack);

    arb_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_wdog (
        .clk     (clk),
        .rst_n   (rst_n),
        .mem_req (mem_req),
        .mem_ack (mem_ack),
        .err     (err)
    );

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: transaction-level model checked every cycle, directed
// scenarios pinned with literal expectations, then randomized traffic and memory latency.
module tb_mem_port_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          i_req, i_kill, i_valid;
    logic [AW-1:0] i_addr;
    logic [DW-1:0] i_rdata;
    logic          d_req, d_we, d_valid;
    logic [2:0]    d_width;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata, d_rdata;
    logic          stall_if, stall_mem;
    logic          mem_req, mem_we, mem_ack;
    logic [2:0]    mem_width;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic          err;

    mem_port_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_req(i_req), .i_addr(i_addr), .i_kill(i_kill), .i_valid(i_valid), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_width(d_width), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_valid(d_valid), .d_rdata(d_rdata),
        .stall_if(stall_if), .stall_mem(stall_mem),
        .mem_req(mem_req), .mem_we(mem_we), .mem_width(mem_width), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .err(err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    function void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    // ---------------- memory responder ----------------
    int          lat_min = 1, lat_max = 4;
    bit          never_ack = 1'b0, spur_en = 1'b0, fix_rd = 1'b1;
    logic [31:0] fix_rdata = 32'h0;
    int          waited = 0, lat = 1;

    initial begin
        mem_ack   = 1'b0;
        mem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            mem_ack = 1'b0;
            if (!rst_n) begin
                waited = 0;
            end else if (mem_req) begin
                if (waited == 0) lat = $urandom_range(lat_max, lat_min);
                if (!never_ack && waited >= lat) begin
                    mem_ack   = 1'b1;
                    mem_rdata = fix_rd ? fix_rdata : $urandom;
                    waited    = 0;
                end else begin
                    waited++;
                end
            end else begin
                waited = 0;
                if (spur_en && $urandom_range(15, 0) == 0) begin
                    mem_ack   = 1'b1;
                    mem_rdata = $urandom;
                end
            end
        end
    end

    // ---------------- transaction-level reference model ----------------
    typedef struct packed {
        logic        vld;
        logic        port_d;
        logic        killed;
        logic        we;
        logic [2:0]  width;
        logic [31:0] addr;
        logic [31:0] wdata;
    } acc_t;

    acc_t        cur;
    bit          p_i, p_d, p_d_load;
    logic [31:0] p_i_dat, p_d_dat;
    int          wc;
    bit          m_err;
    bit          exp_sif, exp_smem;

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_mem_req", 32'(mem_req), 32'd0);
            chk("rst_i_valid", 32'(i_valid), 32'd0);
            chk("rst_d_valid", 32'(d_valid), 32'd0);
            chk("rst_err", 32'(err), 32'd0);
            chk("rst_i_rdata", i_rdata, 32'd0);
            chk("rst_d_rdata", d_rdata, 32'd0);
            cur   = '0;
            p_i   = 1'b0;
            p_d   = 1'b0;
            wc    = 0;
            m_err = 1'b0;
        end else begin
            chk("mem_req", 32'(mem_req), 32'(cur.vld));
            if (cur.vld) begin
                chk("mem_we", 32'(mem_we), 32'(cur.we));
                chk("mem_width", 32'(mem_width), 32'(cur.width));
                chk("mem_addr", mem_addr, cur.addr);
                if (cur.port_d && cur.we) chk("mem_wdata", mem_wdata, cur.wdata);
            end
            chk("i_valid", 32'(i_valid), 32'(p_i));
            if (p_i) chk("i_rdata", i_rdata, p_i_dat);
            chk("d_valid", 32'(d_valid), 32'(p_d));
            if (p_d && p_d_load) chk("d_rdata", d_rdata, p_d_dat);

            exp_sif  = i_req && !(cur.vld && !cur.port_d && !cur.killed && mem_ack && !i_kill);
            exp_smem = d_req && !(cur.vld && cur.port_d && mem_ack);
            chk("stall_if", 32'(stall_if), 32'(exp_sif));
            chk("stall_mem", 32'(stall_mem), 32'(exp_smem));

            // Consecutive cycles an issued access has gone unanswered.
            if (mem_ack) wc = 0;
            else if (cur.vld) wc++;
            if (wc >= TO) m_err = 1'b1;
            chk("err", 32'(err), 32'(m_err));

            p_i = 1'b0;
            p_d = 1'b0;
            if (cur.vld) begin
                if (mem_ack) begin
                    if (cur.port_d) begin
                        p_d      = 1'b1;
                        p_d_load = !cur.we;
                        p_d_dat  = mem_rdata;
                    end else if (!cur.killed && !i_kill) begin
                        p_i     = 1'b1;
                        p_i_dat = mem_rdata;
                    end
                    cur.vld = 1'b0;
                end else if (!cur.port_d && i_kill) begin
                    cur.killed = 1'b1;
                end
            end else if (d_req) begin
                cur.vld = 1'b1; cur.port_d = 1'b1; cur.killed = 1'b0;
                cur.we = d_we; cur.width = d_width; cur.addr = d_addr; cur.wdata = d_wdata;
            end else if (i_req && !i_kill) begin
                cur.vld = 1'b1; cur.port_d = 1'b0; cur.killed = 1'b0;
                cur.we = 1'b0; cur.width = 3'b010; cur.addr = i_addr; cur.wdata = '0;
            end
        end
    end

    // ---------------- directed-window trace ----------------
    logic        t_mreq [32], t_we [32], t_iv [32], t_dv [32], t_sif [32], t_smem [32], t_err [32];
    logic [2:0]  t_w    [32];
    logic [31:0] t_addr [32], t_wd [32], t_ird [32], t_drd [32];
    int          kill_at = -1;
    logic [31:0] kill_addr = '0;

    // Records one cycle per entry; requests drop after their non-stalled cycle.
    task automatic run_window(input int n);
        bit drop_i, drop_d;
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            t_mreq[c] = mem_req;  t_we[c] = mem_we;    t_w[c] = mem_width;
            t_addr[c] = mem_addr; t_wd[c] = mem_wdata;
            t_iv[c] = i_valid;    t_ird[c] = i_rdata;
            t_dv[c] = d_valid;    t_drd[c] = d_rdata;
            t_sif[c] = stall_if;  t_smem[c] = stall_mem; t_err[c] = err;
            drop_i = i_req && !stall_if;
            drop_d = d_req && !stall_mem;
            @(posedge clk);
            #1;
            if (drop_i) i_req = 1'b0;
            if (drop_d) d_req = 1'b0;
            i_kill = (c + 1 == kill_at);
            if (i_kill) i_addr = kill_addr;
        end
    endtask

    task automatic settle();
        i_req = 1'b0; d_req = 1'b0; i_kill = 1'b0; kill_at = -1;
        repeat (8) @(posedge clk);
        #1;
    endtask

    bit s_if, s_mem;

    initial begin
        rst_n = 1'b0;
        i_req = 1'b0; i_addr = '0; i_kill = 1'b0;
        d_req = 1'b0; d_we = 1'b0; d_width = '0; d_addr = '0; d_wdata = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        settle();

        // Fetch only, memory answers two cycles after mem_req.
        lat_min = 2; lat_max = 2; fix_rdata = 32'h00500093;
        i_req = 1'b1; i_addr = 32'h100;
        run_window(6);
        chk("f_grant_no_req", 32'(t_mreq[0]), 32'd0);
        chk("f_req", 32'(t_mreq[1]), 32'd1);
        chk("f_addr", t_addr[1], 32'h100);
        chk("f_width", 32'(t_w[1]), 32'd2);
        chk("f_stall_wait", 32'(t_sif[2]), 32'd1);
        chk("f_stall_ack", 32'(t_sif[3]), 32'd0);
        chk("f_valid", 32'(t_iv[4]), 32'd1);
        chk("f_rdata", t_ird[4], 32'h00500093);
        chk("f_pulse", 32'(t_iv[5]), 32'd0);
        settle();

        // Simultaneous store and fetch: store first.
        i_req = 1'b1; i_addr = 32'h104;
        d_req = 1'b1; d_we = 1'b1; d_width = 3'b010; d_addr = 32'h2000; d_wdata = 32'hDEADBEEF;
        run_window(10);
        chk("s_we", 32'(t_we[1]), 32'd1);
        chk("s_addr", t_addr[1], 32'h2000);
        chk("s_wdata", t_wd[1], 32'hDEADBEEF);
        chk("s_stall_if_ack", 32'(t_sif[3]), 32'd1);
        chk("s_stall_if_dv", 32'(t_sif[4]), 32'd1);
        chk("s_dvalid", 32'(t_dv[4]), 32'd1);
        chk("s_fetch_addr", t_addr[5], 32'h104);
        chk("s_fetch_we", 32'(t_we[5]), 32'd0);
        chk("s_ivalid", 32'(t_iv[8]), 32'd1);
        settle();

        // Kill one cycle after mem_req: drain, then refetch from the new target.
        lat_min = 3; lat_max = 3; d_we = 1'b0;
        i_req = 1'b1; i_addr = 32'h108; kill_at = 2; kill_addr = 32'h200;
        run_window(10);
        chk("k_addr_held", t_addr[3], 32'h108);
        chk("k_req_drain", 32'(t_mreq[4]), 32'd1);
        chk("k_stall_drain", 32'(t_sif[4]), 32'd1);
        chk("k_idle", 32'(t_mreq[5]), 32'd0);
        chk("k_no_valid", 32'(t_iv[5]), 32'd0);
        chk("k_refetch", 32'(t_mreq[6]), 32'd1);
        chk("k_new_addr", t_addr[6], 32'h200);
        settle();

        // Kill in the same cycle as the ack.
        lat_min = 2; lat_max = 2;
        i_req = 1'b1; i_addr = 32'h300; kill_at = 3; kill_addr = 32'h400;
        run_window(8);
        chk("ka_stall", 32'(t_sif[3]), 32'd1);
        chk("ka_no_valid", 32'(t_iv[4]), 32'd0);
        chk("ka_idle", 32'(t_mreq[4]), 32'd0);
        chk("ka_regrant", 32'(t_mreq[5]), 32'd1);
        chk("ka_addr", t_addr[5], 32'h400);
        settle();

        // Byte load at an odd address.
        lat_min = 1; lat_max = 1; fix_rdata = 32'h000000A5;
        d_req = 1'b1; d_we = 1'b0; d_width = 3'b000; d_addr = 32'h2003;
        run_window(5);
        chk("lb_width", 32'(t_w[1]), 32'd0);
        chk("lb_addr", t_addr[1], 32'h2003);
        chk("lb_we", 32'(t_we[1]), 32'd0);
        chk("lb_stall_ack", 32'(t_smem[2]), 32'd0);
        chk("lb_dvalid", 32'(t_dv[3]), 32'd1);
        chk("lb_rdata", t_drd[3], 32'h000000A5);
        settle();

        // Watchdog: memory never answers.
        never_ack = 1'b1;
        d_req = 1'b1; d_we = 1'b0; d_width = 3'b010; d_addr = 32'h40;
        run_window(20);
        chk("wd_before", 32'(t_err[7]), 32'd0);
        chk("wd_set", 32'(t_err[8]), 32'd1);
        chk("wd_sticky", 32'(t_err[19]), 32'd1);
        chk("wd_still_req", 32'(t_mreq[19]), 32'd1);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_mem_req", 32'(mem_req), 32'd0);
        chk("arst_err", 32'(err), 32'd0);
        d_req = 1'b0; never_ack = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        settle();

        // Random traffic against the model.
        fix_rd = 1'b0; spur_en = 1'b1; lat_min = 1; lat_max = 4;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            s_if  = stall_if;
            s_mem = stall_mem;
            @(posedge clk);
            #1;
            if (!(i_req && s_if)) i_req = ($urandom_range(9, 0) < 6);
            if (!(d_req && s_mem)) d_req = ($urandom_range(9, 0) < 3);
            i_addr  = $urandom;
            d_we    = 1'($urandom);
            d_width = 3'($urandom_range(2, 0));
            d_addr  = $urandom;
            d_wdata = $urandom;
            i_kill  = ($urandom_range(9, 0) == 0);
        end
        spur_en = 1'b0;
        settle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
